// File: rtl/harness_pkg.sv
// Shared types and constants for the self-test harness: FSM states, the
// UART banner and the layout of the synchronised input bundle.
package harness_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_CLK,
    SEND,
    DONE
  } state_t;

  localparam int BIT_CNT = 10;
  localparam int N_BYTES = 3;
  localparam logic [7:0] BANNER [N_BYTES] = '{8'h4F, 8'h4B, 8'h0A};

  typedef struct packed {
    logic vip;
    logic vin;
    logic core_reset;
    logic ua_clock;
    logic ua_reset;
    logic ua_rxd;
    logic adcclkrst;
    logic dsp_reset;
    logic adcextclk;
    logic adcclkp;
    logic adcclkm;
  } async_t;

  // 8N1 frame position 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] pos);
    logic b;
    if (pos == 4'd0) b = 1'b0;
    else if (pos <= 4'd8) b = data[3'(pos - 4'd1)];
    else b = 1'b1;
    return b;
  endfunction

endpackage

// File: rtl/test_harness_if.sv
// Pin bundle of the self-test harness; the harness takes the slave side,
// the simulation driver the master side.
interface test_harness_if;
  logic io_clkrxvip;
  logic io_clkrxvin;
  logic io_core_reset;
  logic io_ua_clock;
  logic io_ua_reset;
  logic io_ua_rxd;
  logic io_ua_int;
  logic io_ua_txd;
  logic io_adcclkrst;
  logic io_dsp_reset;
  logic io_ADCBIAS;
  logic io_adcextclk;
  logic io_ADCINP;
  logic io_ADCINM;
  logic io_ADCCLKP;
  logic io_ADCCLKM;
  logic io_success;

  modport slave (
    input  io_clkrxvip, io_clkrxvin, io_core_reset, io_ua_clock, io_ua_reset,
           io_ua_rxd, io_adcclkrst, io_dsp_reset, io_adcextclk, io_ADCCLKP, io_ADCCLKM,
    output io_ua_int, io_ua_txd, io_ADCBIAS, io_ADCINP, io_ADCINM, io_success
  );

  modport master (
    output io_clkrxvip, io_clkrxvin, io_core_reset, io_ua_clock, io_ua_reset,
           io_ua_rxd, io_adcclkrst, io_dsp_reset, io_adcextclk, io_ADCCLKP, io_ADCCLKM,
    input  io_ua_int, io_ua_txd, io_ADCBIAS, io_ADCINP, io_ADCINM, io_success
  );
endinterface

// File: rtl/test_harness_clk_pair_monitor.sv
// Watches one differential clock pair sampled as data: counts rising edges of
// the P leg and flags a sticky error when both legs sit equal for too long.
module clk_pair_monitor #(
  parameter int MIN_EDGES = 8,
  parameter int EQ_LIMIT  = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic p,
  input  logic m,
  input  logic run,
  output logic ok,
  output logic err
);
  localparam int EDGE_W = $clog2(MIN_EDGES + 1);
  localparam int EQ_W   = $clog2(EQ_LIMIT + 1);
  localparam logic [EDGE_W-1:0] EDGE_MAX = EDGE_W'(MIN_EDGES);
  localparam logic [EDGE_W-1:0] EDGE_ONE = EDGE_W'(1);
  localparam logic [EQ_W-1:0]   EQ_MAX   = EQ_W'(EQ_LIMIT);
  localparam logic [EQ_W-1:0]   EQ_PRE   = EQ_W'(EQ_LIMIT - 1);
  localparam logic [EQ_W-1:0]   EQ_ONE   = EQ_W'(1);

  logic              p_prev;
  logic [EDGE_W-1:0] edge_cnt;
  logic [EQ_W-1:0]   eq_cnt;

  always_ff @(posedge clock) p_prev <= p;

  // err survives a run drop; only the chip reset clears it
  always_ff @(posedge clock) begin
    if (!reset) begin
      edge_cnt <= '0;
      eq_cnt   <= '0;
      err      <= 1'b0;
    end else if (!run) begin
      edge_cnt <= '0;
      eq_cnt   <= '0;
    end else begin
      if (p && !p_prev && edge_cnt != EDGE_MAX) edge_cnt <= edge_cnt + EDGE_ONE;
      if (p == m) begin
        if (eq_cnt != EQ_MAX) eq_cnt <= eq_cnt + EQ_ONE;
        if (eq_cnt == EQ_PRE) err <= 1'b1;
      end else begin
        eq_cnt <= '0;
      end
    end
  end

  assign ok = (edge_cnt == EDGE_MAX) && !err;

endmodule

// File: rtl/test_harness.sv
// Top of the self-test harness: checks both clock pairs toggle, drives the
// ADC stimulus, sends "OK\n" over UART and raises a sticky success flag.
module test_harness
  import harness_pkg::*;
#(
  parameter int UART_DIV  = 16,
  parameter int MIN_EDGES = 8,
  parameter int EQ_LIMIT  = 4,
  parameter int ADC_DIV   = 8
) (
  input logic           clock,
  input logic           reset,
  test_harness_if.slave io
);
  localparam int DIV_W = $clog2(UART_DIV);
  localparam int ADC_W = $clog2(ADC_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(UART_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [ADC_W-1:0] ADC_LAST  = ADC_W'(ADC_DIV - 1);
  localparam logic [ADC_W-1:0] ADC_ONE   = ADC_W'(1);
  localparam logic [3:0]       BIT_LAST  = 4'(BIT_CNT - 1);
  localparam logic [1:0]       BYTE_LAST = 2'(N_BYTES - 1);

  async_t async_in, sync_p0, sync_p1;

  assign async_in = '{vip: io.io_clkrxvip, vin: io.io_clkrxvin,
                      core_reset: io.io_core_reset, ua_clock: io.io_ua_clock,
                      ua_reset: io.io_ua_reset, ua_rxd: io.io_ua_rxd,
                      adcclkrst: io.io_adcclkrst, dsp_reset: io.io_dsp_reset,
                      adcextclk: io.io_adcextclk, adcclkp: io.io_ADCCLKP,
                      adcclkm: io.io_ADCCLKM};

  // two-flop synchroniser boundary
  always_ff @(posedge clock) begin
    sync_p0 <= async_in;
    sync_p1 <= sync_p0;
  end

  logic run;
  logic unused_sync;
  assign run = reset && !sync_p1.core_reset && !sync_p1.ua_reset &&
               !sync_p1.dsp_reset && !sync_p1.adcclkrst;
  assign unused_sync = sync_p1.ua_clock ^ sync_p1.ua_rxd ^ sync_p1.adcextclk;

  logic core_ok, core_err, adc_ok, adc_err, ok_all, err_any;

  clk_pair_monitor #(.MIN_EDGES(MIN_EDGES), .EQ_LIMIT(EQ_LIMIT)) u_core_mon (
    .clock(clock), .reset(reset), .p(sync_p1.vip), .m(sync_p1.vin),
    .run(run), .ok(core_ok), .err(core_err)
  );

  clk_pair_monitor #(.MIN_EDGES(MIN_EDGES), .EQ_LIMIT(EQ_LIMIT)) u_adc_mon (
    .clock(clock), .reset(reset), .p(sync_p1.adcclkp), .m(sync_p1.adcclkm),
    .run(run), .ok(adc_ok), .err(adc_err)
  );

  assign ok_all  = core_ok && adc_ok;
  assign err_any = core_err || adc_err;

  state_t           state, state_nxt;
  logic             send_en, done_entry, pass_entry, frame_end;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_idx;
  logic [1:0]       byte_idx;

  assign frame_end = (div_cnt == DIV_LAST) && (bit_idx == BIT_LAST) && (byte_idx == BYTE_LAST);

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!run) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     state_nxt = WAIT_CLK;
        WAIT_CLK: if (err_any) state_nxt = DONE;
                  else if (ok_all) state_nxt = SEND;
        SEND:     if (err_any || frame_end) state_nxt = DONE;
        DONE:     state_nxt = DONE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    send_en    = (state == SEND);
    done_entry = (state != DONE) && (state_nxt == DONE);
    pass_entry = done_entry && !err_any;
  end

  // Counters idle at zero outside SEND so the first start bit begins on entry.
  always_ff @(posedge clock) begin
    if (!reset || !send_en) begin
      div_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      if (bit_idx == BIT_LAST) begin
        bit_idx  <= '0;
        byte_idx <= byte_idx + 2'd1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
      end
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  logic             adc_inp, adc_bias;
  logic [ADC_W-1:0] adc_cnt;

  always_ff @(posedge clock) begin
    if (!reset || !run) begin
      adc_cnt  <= '0;
      adc_inp  <= 1'b0;
      adc_bias <= 1'b0;
    end else begin
      adc_bias <= 1'b1;
      if (adc_cnt == ADC_LAST) begin
        adc_cnt <= '0;
        adc_inp <= !adc_inp;
      end else begin
        adc_cnt <= adc_cnt + ADC_ONE;
      end
    end
  end

  logic int_flag, success_flag;

  always_ff @(posedge clock) begin
    if (!reset) begin
      int_flag     <= 1'b0;
      success_flag <= 1'b0;
    end else begin
      if (done_entry) int_flag     <= 1'b1;
      if (pass_entry) success_flag <= 1'b1;
    end
  end

  assign io.io_ua_txd  = !send_en || frame_bit(BANNER[byte_idx], bit_idx);
  assign io.io_ua_int  = int_flag;
  assign io.io_success = success_flag;
  assign io.io_ADCBIAS = adc_bias;
  assign io.io_ADCINP  = adc_inp;
  assign io.io_ADCINM  = !adc_inp;

endmodule

// File: tb/tb_test_harness.sv
// Self-checking bench for test_harness: randomized reset release order, clock
// phases and reserved-pin noise, checked against a behavioural UART/ADC model.
module tb_test_harness;
  localparam int UART_DIV  = 16;
  localparam int ADC_DIV   = 8;
  localparam int FRAME_CYC = 3 * 10 * UART_DIV;

  logic clock;
  logic reset;
  test_harness_if hif();

  test_harness #(.UART_DIV(UART_DIV), .MIN_EDGES(8), .EQ_LIMIT(4), .ADC_DIV(ADC_DIV)) dut (
    .clock(clock),
    .reset(reset),
    .io(hif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit vin_eq    = 1'b0;
  bit adc_stall = 1'b0;
  logic [7:0] banner_q[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = !clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Pair clocks and reserved-pin noise change on the falling edge only.
  initial begin
    int vip_ph;
    int adc_ph;
    vip_ph = int'($urandom_range(0, 5));
    adc_ph = int'($urandom_range(0, 9));
    hif.io_clkrxvip = 1'b0;
    hif.io_clkrxvin = 1'b1;
    hif.io_ADCCLKP  = 1'b0;
    hif.io_ADCCLKM  = 1'b1;
    hif.io_ua_clock = 1'b0;
    hif.io_ua_rxd   = 1'b1;
    hif.io_adcextclk = 1'b0;
    forever begin
      @(negedge clock);
      vip_ph = (vip_ph + 1) % 6;
      adc_ph = (adc_ph + 1) % 10;
      hif.io_clkrxvip = (vip_ph < 3);
      hif.io_clkrxvin = vin_eq ? (vip_ph < 3) : !(vip_ph < 3);
      hif.io_ADCCLKP  = adc_stall ? 1'b1 : (adc_ph < 5);
      hif.io_ADCCLKM  = adc_stall ? 1'b0 : !(adc_ph < 5);
      hif.io_ua_clock  = 1'($urandom);
      hif.io_ua_rxd    = 1'($urandom);
      hif.io_adcextclk = 1'($urandom);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic assert_all();
    reset = 1'b0;
    hif.io_core_reset = 1'b1;
    hif.io_ua_reset   = 1'b1;
    hif.io_dsp_reset  = 1'b1;
    hif.io_adcclkrst  = 1'b1;
  endtask

  // Releases the five resets in a random order with random gaps.
  task automatic release_all(input bit hold_dsp);
    int order[5];
    for (int i = 0; i < 5; i++) order[i] = i;
    for (int i = 4; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(0, i));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 5; i++) begin
      ticks(int'($urandom_range(0, 4)));
      case (order[i])
        0: reset = 1'b1;
        1: hif.io_core_reset = 1'b0;
        2: hif.io_ua_reset = 1'b0;
        3: hif.io_dsp_reset = hold_dsp;
        default: hif.io_adcclkrst = 1'b0;
      endcase
    end
  endtask

  task automatic uart_rx(output logic [7:0] b, output int t_start);
    int n;
    n = 0;
    b = 8'h00;
    t_start = cyc;
    while (hif.io_ua_txd === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    if (hif.io_ua_txd !== 1'b0) begin
      check_eq("rx_start_timeout", 32'(hif.io_ua_txd), 32'd0);
      return;
    end
    t_start = cyc;
    ticks(UART_DIV / 2);
    check_eq("rx_start_bit", 32'(hif.io_ua_txd), 32'd0);
    for (int i = 0; i < 8; i++) begin
      ticks(UART_DIV);
      b[i] = hif.io_ua_txd;
    end
    ticks(UART_DIV);
    check_eq("rx_stop_bit", 32'(hif.io_ua_txd), 32'd1);
  endtask

  task automatic recv_banner();
    logic [7:0] b;
    int ts;
    int t0;
    int n;
    t0 = 0;
    for (int k = 0; k < 3; k++) begin
      uart_rx(b, ts);
      if (k == 0) t0 = ts;
      check_eq("banner_byte", 32'(b), 32'(banner_q[k]));
    end
    n = 0;
    while (hif.io_success !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check_eq("success_latency", 32'(cyc - t0), 32'(FRAME_CYC));
    check_eq("int_after_banner", 32'(hif.io_ua_int), 32'd1);
  endtask

  initial begin
    string s;
    bit txd_low, succ_seen, bias_seen, int_seen, comp_bad;
    int t_last, n_tog, n;
    logic prev_inp;
    logic [7:0] b;
    int ts;

    s = "OK\n";
    for (int i = 0; i < s.len(); i++) banner_q.push_back(s[i]);

    // reset state
    assert_all();
    ticks(5);
    check_eq("rst_txd", 32'(hif.io_ua_txd), 32'd1);
    check_eq("rst_success", 32'(hif.io_success), 32'd0);
    check_eq("rst_int", 32'(hif.io_ua_int), 32'd0);
    check_eq("rst_adcinm", 32'(hif.io_ADCINM), 32'd1);
    check_eq("rst_adcinp", 32'(hif.io_ADCINP), 32'd0);
    check_eq("rst_bias", 32'(hif.io_ADCBIAS), 32'd0);

    // normal run: banner, success, ADC stimulus
    release_all(1'b0);
    recv_banner();
    check_eq("bias_run", 32'(hif.io_ADCBIAS), 32'd1);
    prev_inp = hif.io_ADCINP;
    t_last = -1; n_tog = 0; comp_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (hif.io_ADCINM !== !hif.io_ADCINP) comp_bad = 1'b1;
      if (hif.io_ADCINP !== prev_inp) begin
        if (t_last >= 0) begin
          check_eq("adc_half_period", 32'(cyc - t_last), 32'(ADC_DIV));
          n_tog++;
        end
        t_last = cyc;
        prev_inp = hif.io_ADCINP;
      end
    end
    check_eq("adc_toggle_count_ge2", 32'(n_tog >= 2), 32'd1);
    check_eq("adc_complementary", 32'(comp_bad), 32'd0);

    // reset pulled mid byte 2, then full banner again
    assert_all();
    ticks(5);
    release_all(1'b0);
    uart_rx(b, ts);
    check_eq("abort_byte1", 32'(b), 32'(banner_q[0]));
    n = 0;
    while (hif.io_ua_txd === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    ticks(int'($urandom_range(0, 14)));
    check_eq("pre_abort_txd", 32'(hif.io_ua_txd), 32'd0);
    reset = 1'b0;
    tick();
    check_eq("abort_txd", 32'(hif.io_ua_txd), 32'd1);
    check_eq("abort_success", 32'(hif.io_success), 32'd0);
    ticks(int'($urandom_range(2, 6)));
    reset = 1'b1;
    recv_banner();

    // core pair legs equal
    assert_all();
    vin_eq = 1'b1;
    ticks(5);
    release_all(1'b0);
    n = 0; succ_seen = 1'b0; txd_low = 1'b0;
    while (hif.io_ua_int !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (hif.io_success === 1'b1) succ_seen = 1'b1;
    end
    check_eq("eq_int", 32'(hif.io_ua_int), 32'd1);
    for (int i = 0; i < 600; i++) begin
      tick();
      if (hif.io_success === 1'b1) succ_seen = 1'b1;
      if (hif.io_ua_txd !== 1'b1) txd_low = 1'b1;
    end
    check_eq("eq_no_success", 32'(succ_seen), 32'd0);
    check_eq("eq_no_send", 32'(txd_low), 32'd0);

    // DSP reset held
    assert_all();
    vin_eq = 1'b0;
    ticks(5);
    release_all(1'b1);
    txd_low = 1'b0; bias_seen = 1'b0; succ_seen = 1'b0; int_seen = 1'b0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (hif.io_ua_txd !== 1'b1) txd_low = 1'b1;
      if (hif.io_ADCBIAS !== 1'b0) bias_seen = 1'b1;
      if (hif.io_success !== 1'b0) succ_seen = 1'b1;
      if (hif.io_ua_int !== 1'b0) int_seen = 1'b1;
    end
    check_eq("dsp_txd_idle", 32'(txd_low), 32'd0);
    check_eq("dsp_bias_off", 32'(bias_seen), 32'd0);
    check_eq("dsp_no_success", 32'(succ_seen), 32'd0);
    check_eq("dsp_no_int", 32'(int_seen), 32'd0);

    // ADC pair stalled
    assert_all();
    adc_stall = 1'b1;
    ticks(5);
    release_all(1'b0);
    txd_low = 1'b0; succ_seen = 1'b0; int_seen = 1'b0;
    for (int i = 0; i < 700; i++) begin
      tick();
      if (hif.io_ua_txd !== 1'b1) txd_low = 1'b1;
      if (hif.io_success !== 1'b0) succ_seen = 1'b1;
      if (hif.io_ua_int !== 1'b0) int_seen = 1'b1;
    end
    check_eq("stall_no_send", 32'(txd_low), 32'd0);
    check_eq("stall_no_success", 32'(succ_seen), 32'd0);
    check_eq("stall_no_int", 32'(int_seen), 32'd0);
    check_eq("stall_bias_on", 32'(hif.io_ADCBIAS), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
    $fatal(1);
  end

endmodule
